store_narrow_unit: RTL and testbench
====================================

Name: store_narrow_unit

Overview:
Store-side counterpart of the CPU's load-path extender. It takes a 32-bit register value and narrows it to a byte, halfword or word, and places the lanes by address. It then generates byte enables and performs one registered req/ack write transaction on the data-memory bus. It sits between the MEM-stage store control and the data-memory port, and reports completion, misalignment and bus timeout to the pipeline.

Parameters:
ADDR_W, 32, width of store and bus addresses
TIMEOUT, 255, max cycles bus_req may stay high without bus_ack before abort (1..255)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
st_valid  in  1  store request valid
st_ready  out  1  unit can accept a request (high only in IDLE)
st_size  in  2  00 byte (sb), 01 halfword (sh), 10 word (sw), 11 illegal
st_addr  in  ADDR_W  byte address of store
st_data  in  32  register value; low 8/16/32 bits used
bus_req  out  1  write request to data memory
bus_addr  out  ADDR_W  word-aligned address, st_addr with [1:0] forced to 00
bus_wdata  out  32  lane-replicated write data
bus_be  out  4  byte enables, bit i = byte lane i
bus_ack  in  1  memory accepted the write
done  out  1  one-cycle pulse: write completed
misalign_err  out  1  one-cycle pulse: misaligned or illegal-size request rejected
timeout_err  out  1  one-cycle pulse: bus_ack never arrived
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, immediate): state IDLE. bus_req=0, bus_addr=0, bus_wdata=0, bus_be=0, done=0, misalign_err=0, timeout_err=0, busy=0, st_ready=1, timeout counter=0.
- Byte ordering is little-endian: byte lane k = st_addr[1:0]==k.
- Narrowing rules, registered at accept:
  - byte: wdata = {4{st_data[7:0]}}, be = 0001 << addr[1:0].
  - half: wdata = {2{st_data[15:0]}}, be = 0011 when addr[1]=0, 1100 when addr[1]=1.
  - word: wdata = st_data, be = 1111.
- Alignment check at accept. Half requires addr[0]=0; word requires addr[1:0]=00; size 11 is always illegal.
- States: IDLE, REQ, RESP.
- IDLE: st_ready=1. Accept when st_valid=1.
  - Legal request: latch addr/wdata/be, go to REQ. bus_req=1 in the cycle after accept.
  - Illegal request: go to RESP with misalign_err pending. No bus activity; bus_be stays 0.
- REQ: bus_req, bus_addr, bus_wdata and bus_be are held stable until the cycle bus_ack is sampled high.
  - On ack: bus_req=0 and bus_be=0 next cycle, done=1 next cycle, go to RESP.
  - Counter increments each REQ cycle without ack. When it reaches TIMEOUT: drop bus_req, pulse timeout_err, go to RESP.
  - Ack in the same cycle the counter reaches TIMEOUT: ack wins, done pulses.
- RESP: exactly one cycle. The done, misalign_err or timeout_err pulse is visible here. busy=1, st_ready=0. Next state is IDLE; the counter clears.
- Latency (legal, ack returned immediately):
  - accept at cycle N
  - bus_req high at N+1
  - ack sampled at N+1
  - done high at N+2
  - st_ready high at N+3
- Errored request: misalign_err pulses at N+1; st_ready is high again at N+2.
- bus_ack while not in REQ is ignored.
- st_valid while st_ready=0 is ignored. Requests are not queued; the issuer must hold st_valid.
- At most one of done / misalign_err / timeout_err is high in any cycle.
- Reset asserted mid-transaction: bus_req drops asynchronously and no completion pulse is produced.

Test Plan:
- sb: st_data=0x123456AB, addr=0x1003, ack immediately -> bus_addr=0x1000, bus_wdata=0xABABABAB, bus_be=1000, done pulse at N+2.
- sh: st_data=0xDEADBEEF, addr=0x2002 -> wdata=0xBEEFBEEF, be=1100. Then sw with addr=0x2004, data=0xCAFEF00D -> be=1111, wdata unchanged from st_data.
- Misaligned: sh at 0x2001, sw at 0x2006, size=11 at 0x2000 -> each gives misalign_err at N+1, bus_req never rises, st_ready back at N+2.
- Ack delayed 5 cycles -> bus_req and all bus fields stable for 6 cycles, single done pulse, counter clear afterwards.
- TIMEOUT=4, no ack -> bus_req high exactly 4 cycles then low, timeout_err pulse, next store proceeds normally. Ack on the 4th cycle -> done, no timeout_err.
- rst pulsed while in REQ -> bus_req=0 immediately, no done pulse. A stray bus_ack after reset has no effect; st_ready=1.

Source files
------------

// File: rtl/store_narrow_unit.sv
// Store-path narrowing unit. It replicates the byte, halfword or word into lanes, builds the
// byte enables, and runs one registered req/ack write on the data-memory bus with a timeout.
module store_narrow_unit #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              st_valid,
   output logic              st_ready,
   input  logic [1:0]        st_size,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [31:0]       st_data,
   output logic              bus_req,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [31:0]       bus_wdata,
   output logic [3:0]        bus_be,
   input  logic              bus_ack,
   output logic              done,
   output logic              misalign_err,
   output logic              timeout_err,
   output logic              busy
);

   // state | meaning
   // IDLE  | ready for a store request
   // REQ   | bus_req held with stable address/data/enables until ack or timeout
   // RESP  | one cycle where the done / misalign_err / timeout_err pulse is visible
   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state, state_nxt;
   logic [7:0]  cnt;
   logic        legal;
   logic [31:0] wdata_nxt;
   logic [3:0]  be_nxt;
   logic        accept, ack_hit, to_hit;

   always_comb begin
      legal     = 1'b0;
      wdata_nxt = st_data;
      be_nxt    = 4'b1111;
      case (st_size)
         2'b00: begin
            legal     = 1'b1;
            wdata_nxt = {4{st_data[7:0]}};
            be_nxt    = 4'b0001 << st_addr[1:0];
         end
         2'b01: begin
            legal     = ~st_addr[0];
            wdata_nxt = {2{st_data[15:0]}};
            be_nxt    = st_addr[1] ? 4'b1100 : 4'b0011;
         end
         2'b10:   legal = (st_addr[1:0] == 2'b00);
         default: legal = 1'b0;
      endcase
   end

   assign accept  = (state == IDLE) && st_valid;
   assign ack_hit = (state == REQ) && bus_ack;
   // an ack arriving on the final allowed cycle takes priority over the timeout
   assign to_hit  = (state == REQ) && !bus_ack && (cnt == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (st_valid) state_nxt = legal ? REQ : RESP;
         REQ:     if (ack_hit || to_hit) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_req      <= 1'b0;
         bus_addr     <= '0;
         bus_wdata    <= '0;
         bus_be       <= '0;
         done         <= 1'b0;
         misalign_err <= 1'b0;
         timeout_err  <= 1'b0;
         cnt          <= '0;
      end else begin
         done         <= ack_hit;
         misalign_err <= accept && !legal;
         timeout_err  <= to_hit;
         if (accept && legal) begin
            bus_req   <= 1'b1;
            bus_addr  <= {st_addr[ADDR_W-1:2], 2'b00};
            bus_wdata <= wdata_nxt;
            bus_be    <= be_nxt;
         end else if (ack_hit || to_hit) begin
            bus_req <= 1'b0;
            bus_be  <= 4'b0000;
         end
         if (state == REQ && !bus_ack) cnt <= cnt + 8'd1;
         else if (state == RESP)       cnt <= '0;
      end
   end

   assign busy     = (state != IDLE);
   assign st_ready = (state == IDLE);

endmodule

// File: tb/tb_store_narrow_unit.sv
// Bench for store_narrow_unit: a short-timeout and a long-timeout instance share stimulus and
// are each checked cycle by cycle against a transaction-level model.
module tb_store_narrow_unit;
   localparam int TO_S = 4;
   localparam int TO_L = 255;

   logic        clk = 1'b0;
   logic        rst;
   logic        st_valid, bus_ack;
   logic [1:0]  st_size;
   logic [31:0] st_addr, st_data;

   logic        rdy_o[2], req_o[2], done_o[2], mis_o[2], to_o[2], busy_o[2];
   logic [31:0] addr_o[2], wdata_o[2];
   logic [3:0]  be_o[2];

   int errs  = 0;
   int total = 0;

   always #5 clk = ~clk;

   store_narrow_unit #(.ADDR_W(32), .TIMEOUT(TO_S)) dut_short (
      .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(rdy_o[0]), .st_size(st_size),
      .st_addr(st_addr), .st_data(st_data), .bus_req(req_o[0]), .bus_addr(addr_o[0]),
      .bus_wdata(wdata_o[0]), .bus_be(be_o[0]), .bus_ack(bus_ack), .done(done_o[0]),
      .misalign_err(mis_o[0]), .timeout_err(to_o[0]), .busy(busy_o[0]));

   store_narrow_unit #(.ADDR_W(32), .TIMEOUT(TO_L)) dut_long (
      .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(rdy_o[1]), .st_size(st_size),
      .st_addr(st_addr), .st_data(st_data), .bus_req(req_o[1]), .bus_addr(addr_o[1]),
      .bus_wdata(wdata_o[1]), .bus_be(be_o[1]), .bus_ack(bus_ack), .done(done_o[1]),
      .misalign_err(mis_o[1]), .timeout_err(to_o[1]), .busy(busy_o[1]));

   typedef struct {
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] data;
      int          dly;   // ack raised in bus cycle dly+1; -1 = never
      bit          ok;
      logic [31:0] wdata;
      logic [3:0]  be;
   } vec_t;

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s dut%0d t=%0t: got %h expected %h", nm, k, $time, act, exp);
      end
   endtask

   function automatic void model(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                                 output bit ok, output logic [31:0] w, output logic [3:0] be);
      int lane = int'(a % 4);
      case (sz)
         2'd0: begin ok = 1'b1; w = (d & 32'hFF) * 32'h01010101; be = 4'(1 << lane); end
         2'd1: begin ok = (lane % 2 == 0); w = (d & 32'hFFFF) * 32'h00010001; be = 4'(3 << lane); end
         2'd2: begin ok = (lane == 0); w = d; be = 4'hF; end
         default: begin ok = 1'b0; w = '0; be = '0; end
      endcase
   endfunction

   // Called at a negedge with both instances idle; returns at a negedge with both idle again.
   task automatic do_store(input vec_t v);
      int r[2];
      bit acked[2];
      int tmo[2];
      int cmax = 0;
      tmo[0] = TO_S;
      tmo[1] = TO_L;
      for (int k = 0; k < 2; k++) begin
         acked[k] = v.ok && v.dly >= 0 && v.dly + 1 <= tmo[k];
         r[k]     = !v.ok ? 0 : (acked[k] ? v.dly + 1 : tmo[k]);
         if (r[k] + 2 > cmax) cmax = r[k] + 2;
      end
      st_valid = 1'b1; st_size = v.size; st_addr = v.addr; st_data = v.data;
      @(posedge clk);
      #1;
      st_valid = 1'b0; st_size = 2'($urandom); st_addr = $urandom; st_data = $urandom;
      for (int c = 1; c <= cmax; c++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            bit in_req = (c <= r[k]);
            bit pulse  = (c == r[k] + 1);
            chk("bus_req", k, req_o[k], in_req);
            if (in_req) begin
               chk("bus_addr", k, addr_o[k], v.addr & ~32'h3);
               chk("bus_wdata", k, wdata_o[k], v.wdata);
               chk("bus_be", k, be_o[k], v.be);
            end else if (!v.ok || acked[k]) begin
               chk("bus_be_idle", k, be_o[k], 4'h0);
            end
            chk("done", k, done_o[k], pulse && acked[k]);
            chk("misalign_err", k, mis_o[k], pulse && !v.ok);
            chk("timeout_err", k, to_o[k], pulse && v.ok && !acked[k]);
            chk("st_ready", k, rdy_o[k], c >= r[k] + 2);
            chk("busy", k, busy_o[k], c < r[k] + 2);
         end
         bus_ack = (v.dly >= 0 && c == v.dly + 1);
      end
      bus_ack = 1'b0;
   endtask

   vec_t tbl[12];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{2'd0, 32'h1003, 32'h123456AB,  0, 1'b1, 32'hABABABAB, 4'b1000};
      tbl[1]  = '{2'd1, 32'h2002, 32'hDEADBEEF,  0, 1'b1, 32'hBEEFBEEF, 4'b1100};
      tbl[2]  = '{2'd2, 32'h2004, 32'hCAFEF00D,  0, 1'b1, 32'hCAFEF00D, 4'b1111};
      tbl[3]  = '{2'd1, 32'h2001, 32'h11111111,  0, 1'b0, 32'h0,        4'b0000};
      tbl[4]  = '{2'd2, 32'h2006, 32'h22222222,  0, 1'b0, 32'h0,        4'b0000};
      tbl[5]  = '{2'd3, 32'h2000, 32'h33333333,  0, 1'b0, 32'h0,        4'b0000};
      tbl[6]  = '{2'd2, 32'h4000, 32'h11223344,  5, 1'b1, 32'h11223344, 4'b1111};
      tbl[7]  = '{2'd1, 32'h6000, 32'hA5A55A5A,  3, 1'b1, 32'h5A5A5A5A, 4'b0011};
      tbl[8]  = '{2'd0, 32'h7002, 32'h000000C3,  4, 1'b1, 32'hC3C3C3C3, 4'b0100};
      tbl[9]  = '{2'd0, 32'h5001, 32'h0000007E, -1, 1'b1, 32'h7E7E7E7E, 4'b0010};
      tbl[10] = '{2'd1, 32'h8006, 32'h12349876,  1, 1'b1, 32'h98769876, 4'b1100};
      tbl[11] = '{2'd0, 32'h9000, 32'h000000FF,  0, 1'b1, 32'hFFFFFFFF, 4'b0001};

      rst = 1'b1; st_valid = 1'b0; bus_ack = 1'b0;
      st_size = 2'd0; st_addr = '0; st_data = '0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_bus_req", k, req_o[k], 1'b0);
         chk("rst_bus_addr", k, addr_o[k], 32'h0);
         chk("rst_bus_wdata", k, wdata_o[k], 32'h0);
         chk("rst_bus_be", k, be_o[k], 4'h0);
         chk("rst_pulses", k, {done_o[k], mis_o[k], to_o[k]}, 3'b000);
         chk("rst_busy", k, busy_o[k], 1'b0);
         chk("rst_st_ready", k, rdy_o[k], 1'b1);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      foreach (tbl[i]) do_store(tbl[i]);

      for (int i = 0; i < 40; i++) begin
         vec_t v;
         int x;
         v.size = 2'($urandom_range(0, 3));
         v.addr = $urandom;
         v.data = $urandom;
         x      = int'($urandom_range(0, 9));
         v.dly  = (x == 9) ? -1 : x;
         model(v.size, v.addr, v.data, v.ok, v.wdata, v.be);
         do_store(v);
      end

      // reset in the middle of a bus request, then a stray ack
      st_valid = 1'b1; st_size = 2'd2; st_addr = 32'h3000; st_data = 32'h0BADF00D;
      @(posedge clk);
      #1 st_valid = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++) chk("pre_rst_bus_req", k, req_o[k], 1'b1);
      #2 rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("async_rst_bus_req", k, req_o[k], 1'b0);
         chk("async_rst_bus_be", k, be_o[k], 4'h0);
         chk("async_rst_st_ready", k, rdy_o[k], 1'b1);
      end
      @(negedge clk);
      rst = 1'b0;
      bus_ack = 1'b1;
      repeat (3) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            chk("stray_ack_bus_req", k, req_o[k], 1'b0);
            chk("stray_ack_pulses", k, {done_o[k], mis_o[k], to_o[k]}, 3'b000);
            chk("stray_ack_st_ready", k, rdy_o[k], 1'b1);
         end
      end
      bus_ack = 1'b0;

      // a normal store after the reset must still work
      do_store(tbl[2]);

      $display("Result: errors=%0d of %0d checks", errs, total);
      $finish;
   end
endmodule
